// File: rtl/bsg_mem_nr1w_sync_init.sv
// Multi-read-port, single-write-port synchronous RAM with a bit write mask, selectable
// read-during-write behaviour, registered read outputs and a zero-fill sweep after reset.
module bsg_mem_nr1w_sync_init #(
    // width_p and els_p must be set by every instantiation; the defaults only let the block elaborate standalone
    parameter int width_p           = 8,
    parameter int els_p             = 8,
    parameter int read_ports_p      = 2,
    parameter int rw_mode_p         = 0,
    parameter int latch_last_read_p = 1,
    parameter int init_on_reset_p   = 1,
    parameter int addr_width_lp     = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    output logic                                   ready_o,
    input  logic                                   w_v_i,
    input  logic [addr_width_lp-1:0]               w_addr_i,
    input  logic [width_p-1:0]                     w_mask_i,
    input  logic [width_p-1:0]                     w_data_i,
    input  logic [read_ports_p-1:0]                r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0]  r_addr_i,
    output logic [read_ports_p*width_p-1:0]        r_data_o
);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_READY} state_e;

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]       mem_q [els_p];

    logic                     ready;
    logic                     sweep;
    logic [addr_width_lp-1:0] w_idx;
    logic                     w_fire;
    logic [width_p-1:0]       w_old, w_merged;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: state_d = (init_on_reset_p != 0) ? S_INIT : S_READY;
            S_INIT: begin
                // Counter stops on the last word rather than wrapping
                if (cnt_q == last_addr_lp) state_d = S_READY;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            S_READY: state_d = S_READY;
            default: state_d = S_RESET;
        endcase
    end

    assign ready   = (state_q == S_READY);
    assign sweep   = (state_q == S_INIT);
    assign ready_o = ready;

    // Single-word memories ignore the address bus entirely
    assign w_idx    = (els_p == 1) ? '0 : w_addr_i;
    assign w_fire   = ready && w_v_i && (int'(w_idx) < els_p);
    assign w_old    = (int'(w_idx) < els_p) ? mem_q[w_idx] : '0;
    assign w_merged = (w_old & ~w_mask_i) | (w_data_i & w_mask_i);

    always_ff @(posedge clk_i) begin
        if (sweep)       mem_q[cnt_q] <= '0;
        else if (w_fire) mem_q[w_idx] <= w_merged;
    end

    for (genvar k = 0; k < read_ports_p; k++) begin : g_rd
        logic [addr_width_lp-1:0] ra;
        logic [width_p-1:0]       old_w, rd_w, rq_q, rq_d;

        assign ra = (els_p == 1) ? '0 : r_addr_i[k*addr_width_lp +: addr_width_lp];

        always_comb begin
            old_w = '0;
            if (int'(ra) < els_p) old_w = mem_q[ra];
            rd_w = old_w;
            if (rw_mode_p == 1 && w_fire && w_idx == ra)
                rd_w = (old_w & ~w_mask_i) | (w_data_i & w_mask_i);
            rq_d = rq_q;
            if (ready) begin
                if (r_v_i[k])                    rq_d = rd_w;
                else if (latch_last_read_p == 0) rq_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) rq_q <= '0;
            else            rq_q <= rq_d;
        end

        assign r_data_o[k*width_p +: width_p] = rq_q;
    end

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_init.sv
// Two memories (5 words old-data/hold, 8 words new-data/clear) share one stimulus stream
// and are compared every cycle against an array-based reference model.
module tb_bsg_mem_nr1w_sync_init;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int P  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          w_v;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_mask, w_data;
    logic [P-1:0]  r_v;
    logic [P*AW-1:0] r_addr;
    logic          rdy_a, rdy_b;
    logic [P*W-1:0] rd_a, rd_b;

    bsg_mem_nr1w_sync_init #(.width_p(W), .els_p(5), .read_ports_p(P), .rw_mode_p(0),
        .latch_last_read_p(1), .init_on_reset_p(1)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .ready_o(rdy_a), .w_v_i(w_v), .w_addr_i(w_addr),
        .w_mask_i(w_mask), .w_data_i(w_data), .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_a));

    bsg_mem_nr1w_sync_init #(.width_p(W), .els_p(8), .read_ports_p(P), .rw_mode_p(1),
        .latch_last_read_p(0), .init_on_reset_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .ready_o(rdy_b), .w_v_i(w_v), .w_addr_i(w_addr),
        .w_mask_i(w_mask), .w_data_i(w_data), .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_b));

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = dut_a, 1 = dut_b
    int          m_els   [2] = '{5, 8};
    int          m_rw    [2] = '{0, 1};
    int          m_latch [2] = '{1, 0};
    int          m_cyc   [2];
    logic [W-1:0] m_mem  [2][8];
    logic [W-1:0] m_rd   [2][P];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(int d);
        return m_cyc[d] >= m_els[d] + 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cyc[d] = 0;
            for (int k = 0; k < P; k++) m_rd[d][k] = '0;
        end
    endtask

    task automatic model_edge();
        int a;
        logic [W-1:0] v;
        if (!rst_n) return;
        for (int d = 0; d < 2; d++) begin
            if (m_ready(d)) begin
                for (int k = 0; k < P; k++) begin
                    a = int'(r_addr[k*AW +: AW]);
                    if (r_v[k]) begin
                        v = (a < m_els[d]) ? m_mem[d][a] : '0;
                        if (m_rw[d] == 1 && w_v && int'(w_addr) == a && a < m_els[d])
                            v = (v & ~w_mask) | (w_data & w_mask);
                        m_rd[d][k] = v;
                    end else if (m_latch[d] == 0) begin
                        m_rd[d][k] = '0;
                    end
                end
                if (w_v && int'(w_addr) < m_els[d])
                    m_mem[d][w_addr] = (m_mem[d][w_addr] & ~w_mask) | (w_data & w_mask);
            end
            m_cyc[d]++;
            if (m_cyc[d] == m_els[d] + 1)
                for (int i = 0; i < 8; i++) m_mem[d][i] = '0;
        end
    endtask

    task automatic check_all();
        chk("ready_a", 32'(rdy_a), 32'(m_ready(0)));
        chk("ready_b", 32'(rdy_b), 32'(m_ready(1)));
        for (int k = 0; k < P; k++) begin
            chk($sformatf("rdata_a[%0d]", k), 32'(rd_a[k*W +: W]), 32'(m_rd[0][k]));
            chk($sformatf("rdata_b[%0d]", k), 32'(rd_b[k*W +: W]), 32'(m_rd[1][k]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        w_v = 1'b0; w_addr = '0; w_mask = '0; w_data = '0; r_v = '0; r_addr = '0;
    endtask

    task automatic wr(input int a, input int d, input int m);
        w_v = 1'b1; w_addr = AW'(a); w_data = W'(d); w_mask = W'(m);
    endtask

    task automatic rd(input int k, input int a);
        r_v[k] = 1'b1;
        r_addr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) m_mem[d][i] = '0;
        model_reset();
        idle();
        repeat (2) step();

        // Release, then attempt accesses during the sweep (must be ignored)
        @(negedge clk); rst_n = 1'b1;
        wr(1, 8'hFF, 8'hFF); rd(0, 1); rd(1, 0);
        repeat (3) step();

        // Abort the sweep mid-way; outputs must drop at once
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        idle();
        repeat (2) step();
        @(negedge clk); rst_n = 1'b1;
        wr(2, 8'h99, 8'hFF); rd(0, 2);
        repeat (10) step();

        // All words read back as zero on both ports, including out-of-range addresses
        idle();
        for (int a = 0; a < 8; a++) begin
            idle(); rd(0, a); rd(1, 7 - a); step();
        end

        // Masked merge into address 3, read on both ports together
        idle(); wr(3, 8'hA5, 8'hFF); step();
        idle(); wr(3, 8'h3C, 8'h0F); step();
        idle(); rd(0, 3); rd(1, 3); step();

        // Read-during-write collision on address 2
        idle(); wr(2, 8'h11, 8'hFF); step();
        idle(); wr(2, 8'hFF, 8'hF0); rd(0, 2); step();
        idle(); rd(0, 2); rd(1, 2); step();

        // Hold versus clear after the last read
        idle(); wr(4, 8'h55, 8'hFF); step();
        idle(); rd(0, 4); rd(1, 4); step();
        idle(); repeat (3) step();

        // Out-of-range write/read (dut_a only; dut_b has 8 words)
        idle(); wr(6, 8'h77, 8'hFF); rd(0, 7); step();
        for (int a = 0; a < 8; a++) begin
            idle(); rd(0, a); rd(1, 6); step();
        end

        // Mask of zero changes nothing
        idle(); wr(3, 8'h00, 8'h00); step();
        idle(); rd(0, 3); step();

        // Random traffic with a bias towards read/write address collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), $urandom, $urandom);
            for (int k = 0; k < P; k++)
                if ($urandom_range(0, 3) != 0)
                    rd(k, ($urandom_range(0, 2) == 0) ? int'(w_addr) : $urandom_range(0, 7));
            step();
        end

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
